// File: rtl/uart_pkg.sv
// uart_pkg: shared UART data width and arbiter state encoding
package uart_pkg;
    localparam int UART_DATA_W = 8;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        ACK       = 3'd4
    } arb_state_e;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set req at or after ptr
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    idx,
    output logic               valid
);
    logic [ID_W-1:0] j;
    // scan from farthest to nearest so the closest hit to ptr wins
    always_comb begin
        idx = '0;
        j   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (req[j]) idx = j;
        end
    end
    assign valid = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among byte requesters
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                         clk_50m,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         err,
    output logic [UART_DATA_W-1:0]       din,
    output logic                         wr_en,
    input  logic                         tx_busy,
    output logic [ID_W-1:0]              cur_id,
    output logic                         active
);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        cur_id_q, cur_id_d, ptr_q, ptr_d, pick_id;
    logic [UART_DATA_W-1:0] din_q, din_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   fault_q, fault_d, pick_valid;

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_id),
        .valid (pick_valid)
    );

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_id_q <= '0;
            ptr_q    <= '0;
            din_q    <= '0;
            cnt_q    <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            ptr_q    <= ptr_d;
            din_q    <= din_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        ptr_d    = ptr_q;
        din_d    = din_q;
        cnt_d    = cnt_q;
        fault_d  = fault_q;
        case (state_q)
            IDLE: if (!tx_busy && pick_valid) begin
                state_d  = LOAD;
                cur_id_d = pick_id;
                din_d    = req_data[int'(pick_id)*UART_DATA_W +: UART_DATA_W];
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
            else begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == CNT_W'(BUSY_TIMEOUT)) begin
                    state_d = ACK;
                    fault_d = 1'b1;
                end
            end
            WAIT_DONE: if (!tx_busy) state_d = ACK;
            ACK: begin
                ptr_d   = (cur_id_q == ID_W'(NUM_REQ - 1)) ? '0 : cur_id_q + 1'b1;
                fault_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_en  = state_q == LOAD;
    assign active = state_q != IDLE;
    assign ack    = (state_q == ACK) ? NUM_REQ'(1) << cur_id_q : '0;
    assign err    = (state_q == ACK) && fault_q;
    assign din    = din_q;
    assign cur_id = cur_id_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench with a behavioural uart busy model
module tb_uart_tx_arbiter;
    localparam int N = 4;
    logic         clk_50m = 1'b0, rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0] ack;
    logic         err, wr_en, tx_busy, active;
    logic [7:0]   din;
    logic [1:0]   cur_id;
    logic         stuck = 1'b0, force_busy = 1'b0;
    int           bcnt = 0;
    int           checks = 0, errors = 0, cyc = 0, wr_cnt = 0, wr_cyc = 0, lat = 0, w0 = 0;
    int           rearm[N];
    logic [N-1:0] pend = '0;
    logic [7:0]   exp_byte[$];
    int           exp_id[$];
    logic         exp_err[$];

    always #10 clk_50m = ~clk_50m;

    uart_tx_arbiter #(.NUM_REQ(N), .ID_W(2), .BUSY_TIMEOUT(15)) dut (
        .clk_50m (clk_50m),
        .rst     (rst),
        .req     (req),
        .req_data(req_data),
        .ack     (ack),
        .err     (err),
        .din     (din),
        .wr_en   (wr_en),
        .tx_busy (tx_busy),
        .cur_id  (cur_id),
        .active  (active)
    );

    // uart stand-in: 12-cycle frame starting after each write, unaffected by arbiter reset
    always @(posedge clk_50m) begin
        if (wr_en && !stuck) bcnt <= 12;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end
    assign tx_busy = force_busy || (bcnt != 0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_tx(input int id, input logic [7:0] b, input logic e);
        exp_byte.push_back(b);
        exp_id.push_back(id);
        exp_err.push_back(e);
    endtask

    task automatic step();
        int id;
        @(negedge clk_50m);
        cyc++;
        for (int i = 0; i < N; i++) if (pend[i]) begin req[i] = 1'b1; pend[i] = 1'b0; end
        if (wr_en) begin
            wr_cnt++;
            wr_cyc = cyc;
            chk("wr_on_idle_line", tx_busy, 0);
            chk("wr_expected", exp_byte.size() != 0, 1);
            if (exp_byte.size() != 0) chk("din", din, exp_byte.pop_front());
        end
        if (ack != 0) begin
            lat = cyc - wr_cyc;
            chk("ack_onehot", $onehot(ack), 1);
            chk("ack_expected", exp_id.size() != 0, 1);
            if (exp_id.size() != 0) begin
                id = exp_id.pop_front();
                chk("ack_id", ack, 32'(1) << id);
                chk("err", err, exp_err.pop_front());
            end
            for (int i = 0; i < N; i++) if (ack[i]) begin
                req[i] = 1'b0;
                if (rearm[i] > 0) begin rearm[i]--; pend[i] = 1'b1; end
            end
        end else if (err) chk("err_without_ack", err, 0);
    endtask

    task automatic run(input int budget);
        int n = 0;
        while (exp_id.size() != 0 && n < budget) begin step(); n++; end
        chk("done_in_budget", exp_id.size(), 0);
        chk("bytes_all_sent", exp_byte.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_din"}, din, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_cur_id"}, cur_id, 0);
        chk({tag, "_active"}, active, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) rearm[i] = 0;
        step(); step();
        check_reset_vals("rst");
        rst = 1'b0;
        // single requester
        req_data[7:0] = 8'h99;
        expect_tx(0, 8'h99, 1'b0);
        req = 4'b0001;
        run(200);
        // all four at once from pointer 0
        rst = 1'b1; step(); step(); rst = 1'b0;
        w0 = wr_cnt;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int i = 0; i < 4; i++) expect_tx(i, 8'hA0 + 8'(i), 1'b0);
        req = 4'b1111;
        run(400);
        chk("all4_wr_count", wr_cnt - w0, 4);
        // fairness: 0 and 2 both re-raise after ack
        req_data = {8'h00, 8'h12, 8'h00, 8'h10};
        rearm[0] = 1; rearm[2] = 1;
        expect_tx(0, 8'h10, 1'b0); expect_tx(2, 8'h12, 1'b0);
        expect_tx(0, 8'h10, 1'b0); expect_tx(2, 8'h12, 1'b0);
        req = 4'b0101;
        run(400);
        // busy never rises: timeout fault
        stuck = 1'b1;
        req_data[15:8] = 8'h55;
        expect_tx(1, 8'h55, 1'b1);
        req = 4'b0010;
        run(100);
        chk("timeout_latency", lat, 16);
        stuck = 1'b0;
        req_data[31:24] = 8'h77;
        expect_tx(3, 8'h77, 1'b0);
        req = 4'b1000;
        run(200);
        // line held busy externally
        force_busy = 1'b1;
        req_data[23:16] = 8'h42;
        w0 = wr_cnt;
        req = 4'b0100;
        repeat (10) step();
        chk("ext_busy_no_wr", wr_cnt - w0, 0);
        chk("ext_busy_inactive", active, 0);
        expect_tx(2, 8'h42, 1'b0);
        force_busy = 1'b0;
        run(200);
        // reset in the middle of a frame
        req_data[7:0] = 8'h31;
        req_data[31:24] = 8'h33;
        exp_byte.push_back(8'h31);
        w0 = wr_cnt;
        req = 4'b0001;
        for (int n = 0; n < 50 && wr_cnt == w0; n++) step();
        chk("midrst_wr_seen", wr_cnt - w0, 1);
        repeat (3) step();
        chk("midrst_line_busy", tx_busy, 1);
        rst = 1'b1;
        req[3] = 1'b1;
        step();
        check_reset_vals("midrst");
        rst = 1'b0;
        expect_tx(0, 8'h31, 1'b0);
        expect_tx(3, 8'h33, 1'b0);
        run(400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
